controle_taxa_contagem: RTL
===========================

# controle_taxa_contagem

Single-clock rate controller and BCD digit counter for the selectable-period counting display path. It derives count-enable pulses at 0.5 s, 1 s, 2 s or 6 s from the 50 MHz board clock, so no derived or gated clocks are needed. It switches rates glitch-free only at period boundaries and optionally auto-steps the rate on every digit wrap. Its digit output feeds the existing 7-segment BCD decoder.

## Interface
- DIV_BASE, default 25_000_000: clock cycles per 0.5 s base period; benches use 4.
- clk  in  1  board clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- sel  in  2  requested rate from the slide switches (async): 0=0.5 s, 1=1 s, 2=2 s, 3=6 s.
- run  in  1  level switch (async): 1 counts, 0 pauses.
- auto_mode  in  1  level switch (async): 1 auto-steps the rate on each wrap and ignores sel.
- clear  in  1  level (async): 1 holds digit and timebase at zero.
- q  out  4  BCD digit, 0..9.
- tick  out  1  one-cycle pulse when q advances.
- wrap  out  1  one-cycle pulse coincident with the tick that takes q from 9 to 0.
- rate  out  2  currently applied rate code.
- state  out  2  FSM state, for debug.

## Operation
- Inputs sel, run, auto_mode and clear each pass through a 2-FF synchronizer. Only the synchronized versions (sel_s, run_s, ...) are used below.
- Timebase:
  - pre counts 0..DIV_BASE-1 and wraps; base_strobe = (pre == DIV_BASE-1) && state != PARADO.
  - mcnt counts base_strobes 0..M-1, with M = 1, 2, 4, 12 for rate 0..3.
  - tick = base_strobe && mcnt == M-1 && state == CONTANDO.
- Digit: on tick, q goes to q+1, or to 0 from 9 with wrap asserted. q never leaves 0..9.
- Target rate tgt:
  - Manual mode: tgt = sel_s.
  - Auto mode: on wrap, tgt register becomes rate+1 mod 4; otherwise it holds.
  - The tgt register is preserved across PARADO.
- FSM states are PARADO (0), CONTANDO (1) and TROCA (2).
  - PARADO: pre, mcnt and q are frozen. Go to CONTANDO when run_s=1.
  - CONTANDO: go to PARADO when run_s=0. Else go to TROCA when tgt != rate.
  - TROCA: pre keeps running and no tick is emitted. At the next base_strobe, rate takes tgt, mcnt is zeroed and the FSM goes to CONTANDO. If run_s=0 it goes to PARADO instead, and rate is unchanged.
- clear_s=1 forces q=0, pre=0 and mcnt=0 every cycle. It has priority over tick. The state and rate are unaffected.
- Simultaneous events:
  - Wrap in auto mode moves the FSM to TROCA on the next cycle.
  - A sel change during TROCA retargets. The latest tgt value is applied at the strobe.
  - If run falls in the same cycle as tick, the tick still counts and the FSM then goes to PARADO.

## Timing
- Reset values: state=PARADO, q=0, rate=0, tgt=0, pre=0, mcnt=0, tick=0, wrap=0. Synchronizer flops reset to 0.
- Input-to-effect latency is 2 cycles of synchronizer plus 1 registered cycle.
- tick, wrap, q, rate and state are registered outputs. q updates in the same cycle tick is high.
- Steady tick period is M·DIV_BASE cycles. The first tick after entering CONTANDO from reset occurs M·DIV_BASE cycles after the FSM enters CONTANDO.
- Rate change:
  - The old tick train stops immediately on entry to TROCA.
  - The new rate applies at the next base_strobe, which is at most DIV_BASE cycles later.
  - The first new tick comes M_new·DIV_BASE cycles after that.
- Reset asserted mid-operation clears everything immediately, asynchronously. Release is sampled on the next clk edge.

## Structure
- Package taxa_pkg holds:
  - the rate enum (TAXA_05S, TAXA_1S, TAXA_2S, TAXA_6S);
  - the state enum (PARADO, CONTANDO, TROCA);
  - the multiplier constants 1, 2, 4, 12 as a function mult(rate).
- Sub-module sincronizador_2ff is parameterized by width. It is instantiated once for sel and once for {run, auto_mode, clear}.
- The top-level board wrapper drives rst from a key (active-low) and q into the BCD decoder.

## Test plan (DIV_BASE=4)
- Reset, then run=1, sel=0 -> a tick every 4 cycles; q counts 0..9, wrap pulses at 9→0, then q=0.
- run=1 at sel=3 -> ticks every 48 cycles; rate=3.
- Mid-count sel 0→2 -> state=TROCA within 3 cycles and no ticks; rate=2 at the next strobe; first tick 16 cycles after that, then every 16.
- auto_mode=1 starting at rate=0 -> after each wrap, rate steps 0→1→2→3→0; tick periods become 4, 8, 16, 48 cycles.
- run=0 at q=5 -> q holds 5 for 100 cycles; run=1 -> counting resumes from 5 with the preserved timebase phase.
- clear=1 for 10 cycles at q=7 -> q=0, with no tick while clear is high; after release, the first tick comes M·4 cycles later. Asserting rst low mid-TROCA -> rate=0 and state=PARADO immediately.

Source files
------------

// File: rtl/taxa_pkg.sv
// taxa_pkg: rate and state encodings shared by the rate controller and its bench-facing ports.
package taxa_pkg;
  typedef enum logic [1:0] {TAXA_05S, TAXA_1S, TAXA_2S, TAXA_6S} taxa_t;
  typedef enum logic [1:0] {PARADO, CONTANDO, TROCA} estado_t;
  function automatic logic [3:0] mult(input taxa_t r);
    return r == TAXA_05S ? 4'd1 : r == TAXA_1S ? 4'd2 : r == TAXA_2S ? 4'd4 : 4'd12;
  endfunction
endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for asynchronous switch levels.
module sincronizador_2ff #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/controle_taxa_contagem.sv
// controle_taxa_contagem: selectable-period BCD counter; rate switches only at base-period boundaries.
module controle_taxa_contagem
  import taxa_pkg::*;
#(parameter int DIV_BASE = 25_000_000) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       run,
  input  logic       auto_mode,
  input  logic       clear,
  output logic [3:0] q,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] rate,
  output logic [1:0] state
);
  localparam int PW = $clog2(DIV_BASE + 1);
  logic [1:0] sel_s;
  logic [2:0] ctl_s;
  logic run_s, auto_s, clear_s;
  estado_t st, st_n;
  taxa_t rt, tgt_r, tgt;
  logic [PW-1:0] pre;
  logic [3:0] mcnt, m;
  logic strobe, last, tick_c, wrap_c;
  sincronizador_2ff #(.W(2)) u_sel (.clk(clk), .rst(rst), .d(sel), .q(sel_s));
  sincronizador_2ff #(.W(3)) u_ctl (.clk(clk), .rst(rst), .d({run, auto_mode, clear}), .q(ctl_s));
  assign {run_s, auto_s, clear_s} = ctl_s;
  assign state = st;
  assign rate = rt;
  always_comb begin
    m = mult(rt);
    strobe = pre == PW'(DIV_BASE - 1) && st != PARADO;
    last = mcnt == m - 4'd1;
    tick_c = strobe && last && st == CONTANDO && !clear_s;
    wrap_c = tick_c && q == 4'd9;
    tgt = auto_s ? tgt_r : taxa_t'(sel_s);
    st_n = st == PARADO   ? (run_s ? CONTANDO : PARADO)
         : st == CONTANDO ? (!run_s ? PARADO : tgt != rt ? TROCA : CONTANDO)
         : !strobe        ? TROCA
         : run_s          ? CONTANDO : PARADO;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st    <= PARADO;
      rt    <= TAXA_05S;
      tgt_r <= TAXA_05S;
      pre   <= '0;
      mcnt  <= '0;
      q     <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      st   <= st_n;
      tick <= tick_c;
      wrap <= wrap_c;
      // manual mode keeps tgt_r tracking sel so entering auto starts from the current selection
      tgt_r <= !auto_s ? taxa_t'(sel_s) : wrap_c ? taxa_t'(rt + 2'd1) : tgt_r;
      if (st == TROCA && strobe && run_s) rt <= tgt;
      if (clear_s) begin
        pre  <= '0;
        mcnt <= '0;
        q    <= '0;
      end else begin
        if (st != PARADO) pre <= strobe ? '0 : pre + PW'(1);
        if (strobe) mcnt <= (st == TROCA || last) ? '0 : mcnt + 4'd1;
        if (tick_c) q <= wrap_c ? 4'd0 : q + 4'd1;
      end
    end
endmodule
